// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : sizing and parameter-legality helpers for sync_fifo_param  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fifo_pkg;

  function automatic int addr_w(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af, input int ae, input int fwft);
    return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1) &&
           ((fwft == 0) || (fwft == 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem_2p : DEPTH x DATA_W array, synchronous write, async read     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [addr_w(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [addr_w(DEPTH)-1:0]   raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_param : parametrised single-clock FIFO, optional FWFT       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         din,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      rd_valid,
  output logic [addr_w(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW    = addr_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W-1:0] AF_T = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

  generate
    if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_param_err
      $error("sync_fifo_param: illegal DEPTH/threshold/FWFT parameter combination");
    end
  endgenerate

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A read frees the slot the simultaneous write needs, so full does not block it.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc)            wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc)            rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !wr_acc)  ovf_d    = 1'b1;
      if (rd_en && !rd_acc)  udf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc && !clr),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (din),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              rd_valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc && !clr;
          if (rd_acc && !clr) dout_q <= mem_rdata;
        end
      end

      assign dout     = dout_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Gate the head to zero when empty so dout never shows unwritten memory.
      assign dout     = empty ? '0 : mem_rdata;
      assign rd_valid = !empty;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_fifo_param : directed self-checking bench, standard and FWFT  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_clr = 1'b0, s_wr = 1'b0, s_rd = 1'b0;
  logic [7:0] s_din = '0;
  logic [7:0] s_dout;
  logic [4:0] s_cnt;
  logic       s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;

  logic       f_clr = 1'b0, f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_din = '0;
  logic [7:0] f_dout;
  logic [4:0] f_cnt;
  logic       f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .wr_en(s_wr), .din(s_din), .rd_en(s_rd),
    .dout(s_dout), .rd_valid(s_rv), .count(s_cnt), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ovf), .underflow(s_udf));

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_en(f_wr), .din(f_din), .rd_en(f_rd),
    .dout(f_dout), .rd_valid(f_rv), .count(f_cnt), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_udf));

  typedef struct {
    logic       wr, rd, clr;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic       e_rv;
    logic [4:0] e_cnt;
    logic       e_empty, e_ovf, e_udf;
  } vec_t;

  vec_t tbl [10];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Packed op word: {wr, rd, clr, din}
  function automatic logic [10:0] op(input logic wr, input logic rd, input logic clr,
                                     input logic [7:0] din);
    return {wr, rd, clr, din};
  endfunction

  task automatic drive(input logic [10:0] s, input logic [10:0] f);
    @(negedge clk);
    {s_wr, s_rd, s_clr, s_din} = s;
    {f_wr, f_rd, f_clr, f_din} = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lvl(input string tag, input int n);
    chk({tag, "_cnt"},   32'(s_cnt),   n);
    chk({tag, "_full"},  32'(s_full),  (n == DEPTH) ? 1 : 0);
    chk({tag, "_empty"}, 32'(s_empty), (n == 0) ? 1 : 0);
    chk({tag, "_af"},    32'(s_af),    (n >= AF) ? 1 : 0);
    chk({tag, "_ae"},    32'(s_ae),    (n <= AE) ? 1 : 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_cnt"},   32'(s_cnt), 0);   chk({tag, "_f_cnt"},   32'(f_cnt), 0);
    chk({tag, "_s_empty"}, 32'(s_empty), 1); chk({tag, "_f_empty"}, 32'(f_empty), 1);
    chk({tag, "_s_full"},  32'(s_full), 0);  chk({tag, "_f_full"},  32'(f_full), 0);
    chk({tag, "_s_ae"},    32'(s_ae), 1);    chk({tag, "_f_ae"},    32'(f_ae), 1);
    chk({tag, "_s_af"},    32'(s_af), 0);    chk({tag, "_f_af"},    32'(f_af), 0);
    chk({tag, "_s_dout"},  32'(s_dout), 0);  chk({tag, "_f_dout"},  32'(f_dout), 0);
    chk({tag, "_s_rv"},    32'(s_rv), 0);    chk({tag, "_f_rv"},    32'(f_rv), 0);
    chk({tag, "_s_ovf"},   32'(s_ovf), 0);   chk({tag, "_f_ovf"},   32'(f_ovf), 0);
    chk({tag, "_s_udf"},   32'(s_udf), 0);   chk({tag, "_f_udf"},   32'(f_udf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] exp;
    logic       rd;

    //            wr    rd    clr   din    | dout   rv    cnt   empty ovf   udf
    tbl[0] = '{1'b1, 1'b1, 1'b0, 8'h33, 8'h55, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h33, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h44, 8'h33, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h33, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h33, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h33, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h66, 8'h33, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h66, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;

    // Fill, walking the thresholds on the way up
    for (int i = 0; i < DEPTH; i++) begin
      drive(op(1'b1, 1'b0, 1'b0, 8'(i)), '0);
      chk_lvl($sformatf("fill%0d", i + 1), i + 1);
    end

    drive(op(1'b1, 1'b0, 1'b0, 8'hAA), '0);
    chk("ovf_set", 32'(s_ovf), 1);
    chk("ovf_cnt", 32'(s_cnt), 16);
    chk("ovf_full", 32'(s_full), 1);

    drive(op(1'b1, 1'b1, 1'b0, 8'h55), '0);
    chk("fullrw_dout", 32'(s_dout), 32'h00);
    chk("fullrw_rv", 32'(s_rv), 1);
    chk("fullrw_cnt", 32'(s_cnt), 16);

    for (int i = 0; i < DEPTH; i++) begin
      drive(op(1'b0, 1'b1, 1'b0, 8'h00), '0);
      exp = (i < DEPTH - 1) ? 8'(i + 1) : 8'h55;
      chk($sformatf("drain%0d_dout", i), 32'(s_dout), 32'(exp));
      chk($sformatf("drain%0d_rv", i), 32'(s_rv), 1);
      chk_lvl($sformatf("drain%0d", i), DEPTH - 1 - i);
    end
    chk("ovf_sticky", 32'(s_ovf), 1);

    drive(op(1'b0, 1'b0, 1'b1, 8'h00), '0);
    chk("clr_cnt", 32'(s_cnt), 0);
    chk("clr_empty", 32'(s_empty), 1);
    chk("clr_ovf", 32'(s_ovf), 0);
    chk("clr_dout", 32'(s_dout), 32'h55);

    for (int i = 0; i < 10; i++) begin
      drive(op(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din), '0);
      chk($sformatf("vec%0d_dout", i), 32'(s_dout), 32'(tbl[i].e_dout));
      chk($sformatf("vec%0d_rv", i), 32'(s_rv), 32'(tbl[i].e_rv));
      chk($sformatf("vec%0d_cnt", i), 32'(s_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(s_empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d_ovf", i), 32'(s_ovf), 32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_udf", i), 32'(s_udf), 32'(tbl[i].e_udf));
    end

    // Interleaved push/pop, enough traffic to wrap the pointers twice
    for (int k = 0; k < 40; k++) begin
      d  = 8'(k * 13 + 5);
      rd = (k >= 3);
      drive(op(1'b1, rd, 1'b0, d), '0);
      if (rd) begin
        exp = q.pop_front();
        chk($sformatf("wrap%0d_dout", k), 32'(s_dout), 32'(exp));
        chk($sformatf("wrap%0d_rv", k), 32'(s_rv), 1);
      end
      q.push_back(d);
      chk($sformatf("wrap%0d_cnt", k), 32'(s_cnt), q.size());
    end
    while (q.size() > 0) begin
      drive(op(1'b0, 1'b1, 1'b0, 8'h00), '0);
      exp = q.pop_front();
      chk("wrapdrain_dout", 32'(s_dout), 32'(exp));
    end
    chk("wrapdrain_empty", 32'(s_empty), 1);
    chk("wrap_udf", 32'(s_udf), 0);

    // FWFT head visibility and pop
    drive('0, op(1'b1, 1'b0, 1'b0, 8'h7E));
    chk("fwft_dout", 32'(f_dout), 32'h7E);
    chk("fwft_rv", 32'(f_rv), 1);
    chk("fwft_cnt", 32'(f_cnt), 1);
    drive('0, '0);
    chk("fwft_hold_dout", 32'(f_dout), 32'h7E);
    chk("fwft_hold_rv", 32'(f_rv), 1);
    drive('0, op(1'b0, 1'b1, 1'b0, 8'h00));
    chk("fwft_pop_empty", 32'(f_empty), 1);
    chk("fwft_pop_rv", 32'(f_rv), 0);
    chk("fwft_pop_cnt", 32'(f_cnt), 0);

    // Build up live state in both instances, then reset between edges
    drive(op(1'b0, 1'b1, 1'b0, 8'h00), '0);
    chk("mid_udf", 32'(s_udf), 1);
    drive(op(1'b1, 1'b0, 1'b0, 8'hA1), op(1'b1, 1'b0, 1'b0, 8'h01));
    drive(op(1'b1, 1'b0, 1'b0, 8'hA2), op(1'b1, 1'b0, 1'b0, 8'h02));
    drive(op(1'b0, 1'b1, 1'b0, 8'h00), op(1'b1, 1'b0, 1'b0, 8'h03));
    chk("mid_s_rv", 32'(s_rv), 1);
    chk("mid_s_dout", 32'(s_dout), 32'hA1);
    chk("mid_f_cnt", 32'(f_cnt), 3);
    chk("mid_f_dout", 32'(f_dout), 32'h01);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    {s_wr, s_rd, s_clr, s_din} = '0;
    {f_wr, f_rd, f_clr, f_din} = '0;
    rst_n = 1'b1;
    drive('0, '0);
    chk("post_s_cnt", 32'(s_cnt), 0);
    chk("post_f_empty", 32'(f_empty), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
